// File: rtl/izigzag_dequant.sv
// izigzag_dequant
//   Inverse-zigzag reorder and dequantization of 8x8 coefficient blocks.
//   Coefficients arrive in zigzag scan order, are multiplied by a 64-entry
//   quant table, saturated to OUT_W, and written into one of two ping-pong
//   banks at their natural (row-major) address. A reader streams each full
//   bank out in natural order, 64 words back to back.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous reset, active HIGH (name kept for compatibility)
//   coef_valid  coef_in/mode_in carry a coefficient this cycle
//   coef_ready  coefficient accepted when coef_valid && coef_ready
//   coef_in     signed coefficient, zigzag order, 64 per block
//   mode_in     transform mode, sampled with coefficient k=0
//   q_we        quant-table write strobe
//   q_addr      quant-table index (zigzag order)
//   q_data      unsigned quant step
//   start       one-cycle pulse with word 0 of each output block
//   x_out       signed dequantized sample, row-major order
//   idct        mode of the block being streamed
//
// Reader FSM
//   state  | meaning
//   IDLE   | waiting for full[rb]
//   STREAM | emitting bank[rb][n], n = 0..63, one word per cycle

module izigzag_dequant #(
  parameter int COEF_W = 12,
  parameter int OUT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     coef_valid,
  output logic                     coef_ready,
  input  logic signed [COEF_W-1:0] coef_in,
  input  logic [1:0]               mode_in,
  input  logic                     q_we,
  input  logic [5:0]               q_addr,
  input  logic [7:0]               q_data,
  output logic                     start,
  output logic signed [OUT_W-1:0]  x_out,
  output logic [1:0]               idct
);

  localparam int PW = COEF_W + 9;
  localparam int SW = (PW > OUT_W) ? PW : OUT_W;
  localparam logic signed [SW-1:0] MAXV = SW'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [SW-1:0] MINV = SW'(-(64'sd1 <<< (OUT_W-1)));

  // zigzag index -> natural row-major address
  localparam logic [5:0] ZZ [0:63] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  logic [7:0]             r_q [0:63];
  logic [OUT_W-1:0]       r_bank [0:127];
  logic [1:0]             r_mode [0:1];
  logic [1:0]             r_full;
  logic [5:0]             r_k;
  logic                   r_wb;
  logic [5:0]             r_n;
  logic                   r_rb;
  state_t                 r_state;
  logic                   r_start;
  logic [OUT_W-1:0]       r_x;
  logic [1:0]             r_idct;

  logic                   w_acc;
  logic [5:0]             w_zz;
  logic signed [PW-1:0]   w_prod;
  logic signed [SW-1:0]   w_prod_x;
  logic [OUT_W-1:0]       w_dq;
  logic [1:0]             w_set;
  logic [1:0]             w_clr;
  logic [1:0]             w_full_nxt;

  assign coef_ready = ~r_full[r_wb];
  assign w_acc      = coef_valid & coef_ready;
  assign w_zz       = ZZ[r_k];

  // Table read is combinational, so a same-cycle q_we to this index only
  // affects later blocks.
  assign w_prod   = PW'(coef_in) * PW'($signed({1'b0, r_q[r_k]}));
  assign w_prod_x = SW'(w_prod);

  always_comb begin
    w_dq = w_prod_x[OUT_W-1:0];
    if (w_prod_x > MAXV)
      w_dq = MAXV[OUT_W-1:0];
    else if (w_prod_x < MINV)
      w_dq = MINV[OUT_W-1:0];
  end

  // Set and clear always target different banks, so both can land together.
  always_comb begin
    w_set = 2'b00;
    w_clr = 2'b00;
    if (w_acc && (r_k == 6'd63))
      w_set[r_wb] = 1'b1;
    if ((r_state == STREAM) && (r_n == 6'd63))
      w_clr[r_rb] = 1'b1;
    w_full_nxt = (r_full & ~w_clr) | w_set;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < 64; i++) r_q[i] <= 8'd1;
    end else if (q_we) begin
      r_q[q_addr] <= q_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc)
      r_bank[{r_wb, w_zz}] <= w_dq;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_k       <= 6'd0;
      r_wb      <= 1'b0;
      r_full    <= 2'b00;
      r_mode[0] <= 2'd0;
      r_mode[1] <= 2'd0;
      r_state   <= IDLE;
      r_n       <= 6'd0;
      r_rb      <= 1'b0;
      r_start   <= 1'b0;
      r_x       <= '0;
      r_idct    <= 2'd0;
    end else begin
      r_full  <= w_full_nxt;
      r_start <= 1'b0;

      if (w_acc) begin
        if (r_k == 6'd0)
          r_mode[r_wb] <= mode_in;
        if (r_k == 6'd63) begin
          r_k  <= 6'd0;
          r_wb <= ~r_wb;
        end else begin
          r_k <= r_k + 6'd1;
        end
      end

      case (r_state)
        IDLE: begin
          if (r_full[r_rb]) begin
            r_state <= STREAM;
            r_n     <= 6'd0;
          end
        end
        STREAM: begin
          r_x     <= r_bank[{r_rb, r_n}];
          r_start <= (r_n == 6'd0);
          r_idct  <= r_mode[r_rb];
          if (r_n == 6'd63) begin
            r_n     <= 6'd0;
            r_rb    <= ~r_rb;
            r_state <= IDLE;
          end else begin
            r_n <= r_n + 6'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign start = r_start;
  assign x_out = r_x;
  assign idct  = r_idct;

endmodule

// File: tb/tb_izigzag_dequant.sv
// Bench for izigzag_dequant: directed blocks, expected words queued at
// stimulus time, compared by an independent output monitor.

module tb_izigzag_dequant;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               coef_valid = 1'b0;
  logic               coef_ready;
  logic signed [11:0] coef_in = '0;
  logic [1:0]         mode_in = 2'd0;
  logic               q_we = 1'b0;
  logic [5:0]         q_addr = 6'd0;
  logic [7:0]         q_data = 8'd0;
  logic               start;
  logic signed [15:0] x_out;
  logic [1:0]         idct;

  izigzag_dequant #(.COEF_W(12), .OUT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .coef_valid(coef_valid), .coef_ready(coef_ready),
    .coef_in(coef_in), .mode_in(mode_in), .q_we(q_we), .q_addr(q_addr),
    .q_data(q_data), .start(start), .x_out(x_out), .idct(idct)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        st;
    logic [15:0] x;
    logic [1:0]  m;
  } exp_t;

  exp_t exp_q[$];
  int   st_cyc[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   zz[64];
  int   qm[64];
  int   blk_c[64];
  int   cap[64];
  int   capm[64];
  int   mcnt = -1;
  int   acc_cyc = 0;
  int   stall_k0 = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int sat16(input int p);
    if (p > 32767) return 32767;
    if (p < -32768) return -32768;
    return p;
  endfunction

  // Output monitor: a block is start plus the 63 words that follow it.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      mcnt = -1;
    end else begin
      if (start) mcnt = 0;
      else if (mcnt >= 0 && mcnt < 63) mcnt++;
      else mcnt = -1;
      if (mcnt >= 0) begin
        if (start) st_cyc.push_back(cyc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL word%0d: output word with nothing expected (x=%0d)", mcnt, x_out);
        end else begin
          e = exp_q.pop_front();
          if ({start, x_out, idct} !== e) begin
            errors++;
            $display("FAIL word%0d: got start=%0d x=%0d idct=%0d, expected start=%0d x=%0d idct=%0d",
                     mcnt, start, x_out, idct, e.st, $signed(e.x), e.m);
          end
        end
        cap[mcnt]  = int'(x_out);
        capm[mcnt] = int'(idct);
      end
    end
  end

  task automatic q_write(input int a, input int d);
    @(negedge clk);
    q_we = 1'b1; q_addr = 6'(a); q_data = 8'(d);
    @(negedge clk);
    q_we = 1'b0;
    qm[a] = d;
  endtask

  task automatic drop_valid();
    @(negedge clk);
    coef_valid = 1'b0;
    q_we = 1'b0;
  endtask

  // Sends blk_c[0..63] in zigzag order; optional table write coincident
  // with accept of coefficient coll_k.
  task automatic send_block(input int mode, input int coll_k, input int coll_d);
    int e_nat[64];
    int guard;
    for (int k = 0; k < 64; k++) e_nat[zz[k]] = sat16(blk_c[k] * qm[k]);
    stall_k0 = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      q_we = 1'b0;
      coef_valid = 1'b1;
      coef_in = 12'(blk_c[k]);
      mode_in = (k == 0) ? 2'(mode) : ~2'(mode);
      guard = 0;
      while (!coef_ready && guard < 300) begin
        if (k == 0) stall_k0++;
        guard++;
        @(negedge clk);
      end
      if (guard >= 300) begin
        chk("ready_timeout", guard, 0);
        coef_valid = 1'b0;
        return;
      end
      if (k == coll_k) begin
        q_we = 1'b1; q_addr = 6'(coll_k); q_data = 8'(coll_d);
      end
      if (k == 63) acc_cyc = cyc + 1;
      @(posedge clk);
    end
    for (int n = 0; n < 64; n++)
      exp_q.push_back('{st: (n == 0), x: 16'(e_nat[n]), m: 2'(mode)});
    if (coll_k >= 0) qm[coll_k] = coll_d;
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((exp_q.size() != 0 || mcnt != -1) && g < 1000) begin
      @(negedge clk); #1;
      g++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    int r, c, s1, s2, s3, nst, cnt2, g;
    r = 0; c = 0;
    for (int k = 0; k < 64; k++) begin
      zz[k] = r * 8 + c;
      if (((r + c) % 2) == 0) begin
        if (c == 7) r++;
        else if (r == 0) c++;
        else begin r--; c++; end
      end else begin
        if (r == 7) c++;
        else if (c == 0) r++;
        else begin r++; c--; end
      end
      qm[k] = 1;
    end

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_coef_ready", int'(coef_ready), 1);
    chk("rst_start", int'(start), 0);
    chk("rst_x_out", int'(x_out), 0);
    chk("rst_idct", int'(idct), 0);
    rst_n = 1'b0;

    // ramp through unit table, mode 2
    for (int k = 0; k < 64; k++) blk_c[k] = k;
    send_block(2, -1, 0);
    drop_valid();
    wait_drain();
    chk("latency", (st_cyc.size() > 0) ? st_cyc[st_cyc.size()-1] - acc_cyc : -1, 2);
    chk("nat1", cap[1], 1);
    chk("nat8", cap[8], 2);
    chk("nat16", cap[16], 3);
    chk("nat9", cap[9], 4);
    cnt2 = 0;
    for (int n = 0; n < 64; n++) if (capm[n] == 2) cnt2++;
    chk("idct_held", cnt2, 64);

    // saturation
    q_write(0, 200);
    q_write(3, 255);
    for (int k = 0; k < 64; k++) blk_c[k] = k - 32;
    blk_c[0] = 300;
    blk_c[3] = 2047;
    send_block(1, -1, 0);
    drop_valid();
    wait_drain();
    chk("sat_pos", cap[0], 32767);
    blk_c[0] = -300;
    send_block(3, -1, 0);
    drop_valid();
    wait_drain();
    chk("sat_neg", cap[0], -32768);

    // three blocks back to back, valid held high
    for (int k = 0; k < 64; k++) blk_c[k] = 7 + k - 20;
    send_block(0, -1, 0); s1 = stall_k0;
    for (int k = 0; k < 64; k++) blk_c[k] = 14 - k;
    send_block(1, -1, 0); s2 = stall_k0;
    for (int k = 0; k < 64; k++) blk_c[k] = 21 + 2 * k;
    send_block(2, -1, 0); s3 = stall_k0;
    drop_valid();
    wait_drain();
    chk("stall_blk1", s1, 0);
    chk("stall_blk2", s2, 0);
    chk("stall_blk3", s3, 1);
    nst = st_cyc.size();
    chk("gap_1_2", (nst >= 3) ? st_cyc[nst-2] - st_cyc[nst-3] : -1, 65);
    chk("gap_2_3", (nst >= 3) ? st_cyc[nst-1] - st_cyc[nst-2] : -1, 65);

    // table write coincident with accept of k=5
    for (int k = 0; k < 64; k++) blk_c[k] = 10;
    send_block(1, 5, 4);
    drop_valid();
    wait_drain();
    chk("coll_old_q", cap[2], 10);
    send_block(1, -1, 0);
    drop_valid();
    wait_drain();
    chk("coll_new_q", cap[2], 40);

    // reset mid-stream at word 30
    for (int k = 0; k < 64; k++) blk_c[k] = k + 100;
    send_block(3, -1, 0);
    drop_valid();
    g = 0;
    while (mcnt != 30 && g < 300) begin
      @(negedge clk); #1;
      g++;
    end
    chk("reach_word30", mcnt, 30);
    rst_n = 1'b1;
    #1;
    chk("abort_start", int'(start), 0);
    chk("abort_x_out", int'(x_out), 0);
    chk("abort_ready", int'(coef_ready), 1);
    chk("abort_idct", int'(idct), 0);
    chk("abort_pending", exp_q.size(), 33);
    exp_q.delete();
    for (int k = 0; k < 64; k++) qm[k] = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    for (int k = 0; k < 64; k++) blk_c[k] = 63 - k;
    send_block(2, -1, 0);
    drop_valid();
    wait_drain();
    chk("fresh_nat0", cap[0], 63);
    chk("fresh_nat63", cap[63], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
